// File: rtl/uart_pkg.sv
// Shared UART timing constants and the rounded baud divisor helper.
// RX/TX blocks reuse baud_div so their timing checks agree with the tick generator.
package uart_pkg;

    localparam int unsigned CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned BAUD_RATE   = 115_200;
    localparam int unsigned OVERSAMPLE  = 16;

    // Round to nearest; a zero tick rate yields 0 so callers can reject it at elaboration.
    function automatic int unsigned baud_div(input longint unsigned clk,
                                             input longint unsigned baud,
                                             input longint unsigned os);
        longint unsigned rate;
        rate = baud * os;
        if (rate == 0) begin
            return 0;
        end
        return int'((clk + rate / 2) / rate);
    endfunction

endpackage

// File: rtl/baudrate.sv
// Free-running oversampling tick generator for the UART.
// Integer mode divides by a rounded constant; fractional mode tracks the exact average rate.
module baudrate #(
    parameter int unsigned CLK_FREQ_HZ = uart_pkg::CLK_FREQ_HZ,
    parameter int unsigned BAUD_RATE   = uart_pkg::BAUD_RATE,
    parameter int unsigned OVERSAMPLE  = uart_pkg::OVERSAMPLE,
    parameter int unsigned FRACTIONAL  = 0
) (
    input  logic i_clk,
    input  logic i_br_rst,
    output logic o_b_tick
);

    localparam int unsigned     DIV = uart_pkg::baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
    localparam longint unsigned INC = longint'(BAUD_RATE) * longint'(OVERSAMPLE);

    // A divisor below 2 (or a rate above half the clock) would put ticks on consecutive cycles.
    if (CLK_FREQ_HZ == 0 || BAUD_RATE == 0 || OVERSAMPLE == 0) begin : g_zero_param
        $error("baudrate: CLK_FREQ_HZ, BAUD_RATE and OVERSAMPLE must be non-zero");
    end
    if (FRACTIONAL == 0 && DIV < 2) begin : g_div_too_small
        $error("baudrate: integer divisor %0d is below 2", DIV);
    end
    if (FRACTIONAL != 0 && INC * 2 > longint'(CLK_FREQ_HZ)) begin : g_inc_too_large
        $error("baudrate: tick rate %0d exceeds half the clock", INC);
    end

    logic tick;

    if (FRACTIONAL == 0) begin : g_integer
        localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
        localparam logic [CW-1:0] LAST = CW'(DIV - 1);

        logic [CW-1:0] count;

        always_ff @(posedge i_clk) begin
            if (i_br_rst) begin
                count <= '0;
                tick  <= 1'b0;
            end else if (count == LAST) begin
                count <= '0;
                tick  <= 1'b1;
            end else begin
                count <= count + CW'(1);
                tick  <= 1'b0;
            end
        end
    end else begin : g_fractional
        localparam int AW = $clog2(longint'(CLK_FREQ_HZ) + INC) + 1;
        localparam logic [AW-1:0] INC_W = AW'(INC);
        localparam logic [AW-1:0] CLK_W = AW'(CLK_FREQ_HZ);

        logic [AW-1:0] acc;
        logic [AW-1:0] sum;

        // Accumulator stays in [0, CLK_FREQ_HZ); each wrap past the clock rate is one tick.
        always_comb begin
            sum = acc + INC_W;
        end

        always_ff @(posedge i_clk) begin
            if (i_br_rst) begin
                acc  <= '0;
                tick <= 1'b0;
            end else if (sum >= CLK_W) begin
                acc  <= sum - CLK_W;
                tick <= 1'b1;
            end else begin
                acc  <= sum;
                tick <= 1'b0;
            end
        end
    end

    assign o_b_tick = tick;

endmodule

// File: tb/tb_baudrate.sv
// Self-checking bench: integer, fractional and minimum-divisor tick generators side by side.
module tb_baudrate;

    localparam int     DIV      = 54;
    localparam longint CLK_HZ   = 100_000_000;
    localparam longint INC      = 1_843_200;
    localparam int     HORIZON  = 21_600;

    logic clk      = 1'b0;
    logic rst_main = 1'b1;
    logic rst_aux  = 1'b1;
    logic tick_int;
    logic tick_frac;
    logic tick_small;

    always #5 clk = ~clk;

    baudrate dut_int (
        .i_clk    (clk),
        .i_br_rst (rst_main),
        .o_b_tick (tick_int)
    );

    baudrate #(.FRACTIONAL(1)) dut_frac (
        .i_clk    (clk),
        .i_br_rst (rst_aux),
        .o_b_tick (tick_frac)
    );

    baudrate #(.CLK_FREQ_HZ(1600), .BAUD_RATE(50), .OVERSAMPLE(16)) dut_small (
        .i_clk    (clk),
        .i_br_rst (rst_aux),
        .o_b_tick (tick_small)
    );

    int     checks = 0;
    int     errors = 0;
    int     int_edge = 0;
    int     aux_edge = 0;
    int     exp_q[$];
    logic   count_en = 1'b0;
    int     int_ticks = 0;
    int     ticks_before_2300 = 0;
    longint first_tick_time = -1;
    int     frac_ticks = 0;
    int     frac_last = 0;
    logic   small_prev = 1'b0;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_num(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard: expected tick edges (counted from reset release) for the integer divider.
    task automatic applyStimulus(input int horizon);
        exp_q.delete();
        for (int i = 1; DIV * i <= horizon; i++) begin
            exp_q.push_back(DIV * i);
        end
    endtask

    task automatic checkOutput();
        logic   exp_int;
        logic   exp_frac;
        logic   exp_small;
        longint k;
        int     gap;
        exp_int = 1'b0;
        if (!rst_main && exp_q.size() > 0 && exp_q[0] == int_edge) begin
            exp_int = 1'b1;
            void'(exp_q.pop_front());
        end
        check_bit("int_tick", tick_int, exp_int);
        if (tick_int && count_en) begin
            int_ticks++;
            if ($time < 2300) ticks_before_2300++;
            if (first_tick_time < 0) first_tick_time = $time;
        end

        k = longint'(aux_edge);
        exp_frac = 1'b0;
        if (!rst_aux && k > 0) begin
            exp_frac = ((k * INC) / CLK_HZ) != (((k - 1) * INC) / CLK_HZ);
        end
        check_bit("frac_tick", tick_frac, exp_frac);
        if (tick_frac) begin
            frac_ticks++;
            if (frac_last > 0) begin
                gap = aux_edge - frac_last;
                check_bit("frac_gap_54_55", (gap == 54 || gap == 55), 1'b1);
            end
            frac_last = aux_edge;
        end

        exp_small = !rst_aux && aux_edge > 0 && (aux_edge % 2 == 0);
        check_bit("small_tick", tick_small, exp_small);
        check_bit("small_no_double", small_prev && tick_small, 1'b0);
        small_prev = tick_small;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_main) int_edge = 0; else int_edge++;
        if (rst_aux)  aux_edge = 0; else aux_edge++;
        #1;
        checkOutput();
    endtask

    initial begin
        logic found;
        $display("[TB] start");

        step();
        step();
        #6;
        rst_main = 1'b0;
        rst_aux  = 1'b0;
        applyStimulus(HORIZON);

        count_en = 1'b1;
        repeat (10_000) step();
        count_en = 1'b0;
        check_bit("first_tick_window", (first_tick_time >= 555 && first_tick_time <= 565), 1'b1);
        check_num("ticks_before_2300ns", ticks_before_2300, 4);
        check_num("int_ticks_10k_cycles", int_ticks, 185);

        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            step();
            found = tick_int;
        end
        check_bit("tick_seen_before_reset", found, 1'b1);
        repeat (30) step();
        rst_main = 1'b1;
        repeat (3) step();
        rst_main = 1'b0;
        applyStimulus(HORIZON);

        while (aux_edge < 20_000) step();
        check_num("frac_ticks_20k_cycles", frac_ticks, (20_000 * INC) / CLK_HZ);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baudrate.md
Name: baudrate

Overview:
- Free-running baud-rate tick generator for the UART.
- Divides the system clock into a single-cycle strobe `o_b_tick` at BAUD_RATE × OVERSAMPLE Hz.
- The UART RX and TX state machines consume this strobe as their oversampling tick.
- Two divider modes: integer divider (default) and fractional phase-accumulator (exact long-term average rate).

Parameters:
- CLK_FREQ_HZ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: serial bit rate in baud.
- OVERSAMPLE, 16: ticks per bit period.
- FRACTIONAL, 0: 0 = integer divider; 1 = phase-accumulator divider.
- DIV (localparam): round(CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE)); 54 with the defaults.
- INC (localparam): BAUD_RATE*OVERSAMPLE; 1_843_200 with the defaults.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_br_rst  input  1  synchronous, active-high reset.
- o_b_tick  output  1  registered one-cycle strobe at the tick rate.

Behaviour:
- Single clock domain; no combinational path from any input to `o_b_tick`.
- Reset: while `i_br_rst`=1 at a rising edge:
  - counter/accumulator cleared to 0;
  - `o_b_tick` <= 0.
- Reset asserted mid-count discards the partial count. No tick is emitted on that edge or while reset stays high.
- Integer mode (FRACTIONAL=0):
  - counter width = $clog2(DIV); counter runs 0..DIV-1.
  - At an edge with counter==DIV-1: counter <= 0 and `o_b_tick` <= 1.
  - Otherwise: counter <= counter+1 and `o_b_tick` <= 0.
  - Tick period is exactly DIV cycles; high for exactly 1 cycle.
  - First tick is registered on the DIV-th rising edge after reset deasserts.
- Fractional mode (FRACTIONAL=1):
  - accumulator width = $clog2(CLK_FREQ_HZ+INC)+1, unsigned; held in [0, CLK_FREQ_HZ).
  - At each edge form sum = acc+INC.
  - If sum >= CLK_FREQ_HZ: acc <= sum-CLK_FREQ_HZ and `o_b_tick` <= 1.
  - Else: acc <= sum and `o_b_tick` <= 0.
  - Tick spacing is floor or ceil of CLK_FREQ_HZ/INC cycles (54 or 55 with the defaults).
  - Tick count over N cycles = floor(N*INC/CLK_FREQ_HZ), ±1.
- `o_b_tick` is never high on two consecutive cycles; guaranteed by the elaboration check below.
- Elaboration checks (`$error`), all fatal:
  - integer mode: DIV < 2;
  - fractional mode: INC*2 > CLK_FREQ_HZ;
  - any parameter equal to 0.
- No wrap hazard: the counter resets at DIV-1 and never passes it.
- No enable input; the generator runs continuously out of reset.

Decomposition:
- Package `uart_pkg`:
  - default constants CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE;
  - constant function `baud_div(clk, baud, os)` returning the rounded divisor, shared with the RX/TX blocks for timing checks.
- No sub-module; integer and fractional paths are two generate branches in one module.

Test Plan:
- Integer reset release:
  - stimulus: defaults; 100 MHz clock (10 ns); reset high until 22 ns.
  - response: `o_b_tick`=0 during reset; first tick high 555–565 ns; later ticks at 1095, 1635 and 2175 ns; exactly 4 ticks before 2300 ns.
- Pulse shape:
  - stimulus: run 10 000 cycles, defaults.
  - response: every tick exactly 1 cycle wide; every gap exactly 54 cycles; total 185 ticks (±1).
- Reset mid-operation:
  - stimulus: assert reset for 3 cycles, 30 cycles after a tick.
  - response: no tick during reset; next tick exactly 54 edges after reset deasserts.
- Fractional mode:
  - stimulus: FRACTIONAL=1, defaults, run 100 000 cycles.
  - response: all gaps are 54 or 55; tick count 1843 ±1.
- Small divisor:
  - stimulus: CLK_FREQ_HZ=1600, BAUD_RATE=50, OVERSAMPLE=16 (DIV=2).
  - response: tick alternates 0/1 every cycle after reset; never high two cycles in a row.
- Parameter check:
  - stimulus: DIV would be 1 (CLK_FREQ_HZ=1600, BAUD_RATE=100, OVERSAMPLE=16).
  - response: elaboration fails with `$error`.
